data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's data memory port. It receives the address, write data, write strobe and width control that the MEM stage drives.
- Returns read data one cycle later, aligned with the WB stage's sampling of load data.
- Contains a word-organised RAM with byte-lane writes, sign/zero extension of loads, misalignment detection and one memory-mapped "tohost" register for simulation termination.
- Sits outside the core, beside the instruction memory, in the top-level and testbench.

Parameters:
- size, 32, data/address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; must be a power of two.
- TOHOST_ADDR, 32'h0000_FFF0, byte address of the tohost register.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- data_mem_rw  input  1  1 = write request this cycle, 0 = read
- data_mem_addr_i  input  size  byte address
- data_mem_data_wr_data  input  size  store data, right-aligned (byte in [7:0], half in [15:0])
- data_mem_control  input  3  funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- data_mem_data_rd_data  output  size  registered load result, extended to 32 bits
- misaligned_o  output  1  one-cycle pulse, registered, flags a bad access in the previous cycle
- tohost_valid_o  output  1  one-cycle pulse when tohost is written
- tohost_data_o  output  size  last value written to tohost; held until the next write or reset

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - data_mem_data_rd_data = 0, misaligned_o = 0, tohost_valid_o = 0, tohost_data_o = 0.
  - RAM contents are NOT cleared.
  - A request presented in a cycle where reset=1 is dropped: no write, no flag.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so the RAM aliases. The only exception is the exact TOHOST_ADDR match.
- Alignment is legal when:
  - B/BU: always.
  - H/HU: addr[0]=0.
  - W: addr[1:0]=00.
  - Codes 011, 110 and 111 are illegal for both reads and writes.
- Write, when rw=1, legal, and addr != TOHOST_ADDR:
  - B: write lane addr[1:0] with wr_data[7:0].
  - H: write lanes {addr[1],0} and {addr[1],1} with wr_data[15:0].
  - W: write all 4 lanes.
  - Commit happens at the rising edge; unselected lanes are unchanged.
  - Little-endian: lane 0 is bits [7:0].
  - Next-cycle data_mem_data_rd_data = 0.
- Write, when rw=1, legal, addr == TOHOST_ADDR, control=W:
  - The RAM is untouched.
  - tohost_data_o <= wr_data and tohost_valid_o = 1 for exactly one cycle.
  - A tohost write of non-W width counts as illegal.
- Read, when rw=0, legal:
  - Latency is 1 cycle: the value requested in cycle N appears in cycle N+1.
  - The lane(s) selected by addr[1:0] are shifted to the LSBs.
  - B/H sign-extend; BU/HU zero-extend; W is passed through.
  - A read of TOHOST_ADDR returns tohost_data_o.
  - Reads have no side effects. The core issues them every cycle, including for non-memory instructions.
- Illegal access (misaligned or reserved code):
  - A write is suppressed.
  - data_mem_data_rd_data = 0 in the next cycle.
  - misaligned_o = 1 for one cycle.
  - When rw=0 with an illegal code, the flag is still raised. Non-load instructions may present any address, so the core must ignore the flag unless the WB instruction is a load.
- Read-after-write to the same word in back-to-back cycles returns the new data (the write committed at the preceding edge).
- No stalls and no ready signal: every request completes in a fixed single cycle.

Test Plan:
- Reset and tohost:
  - Stimulus: assert reset for 2 cycles while driving rw=1, W, addr 0x10, data 0xDEADBEEF. Release reset, then issue a W read of 0x10.
  - Required: all outputs are 0 during reset. The read returns the pre-loaded value, proving the write was dropped.
- Byte write/read with extension:
  - Stimulus: W-write 0x11223344 to 0x20. SB 0x80 to 0x21. Then LB 0x21, LBU 0x21 and LW 0x20 on consecutive cycles.
  - Required: 0xFFFFFF80, then 0x00000080, then 0x11228044.
- Halfword lanes:
  - Stimulus: SH 0xBEEF to 0x42. Then LH 0x42, LHU 0x42 and LW 0x40.
  - Required: 0xFFFFBEEF, then 0x0000BEEF, then 0xBEEFxxxx, with the lower half unchanged.
- Misalignment:
  - Stimulus: SW 0xCAFEBABE to 0x43. Then LH 0x41.
  - Required: the SW raises misaligned_o 1 cycle later and word 0x40 is unchanged. The LH returns 0 with misaligned_o=1.
  - Also: a reserved code 011 read flags as well.
- Back-to-back RAW and aliasing:
  - Stimulus: SW 0x5A5A5A5A to 0x100, next cycle LW 0x100. Then LW 0x100 + 4*DEPTH_WORDS.
  - Required: both reads return 0x5A5A5A5A.
- Tohost:
  - Stimulus: SW 0x00000001 to TOHOST_ADDR.
  - Required: tohost_valid_o is high for exactly 1 cycle and tohost_data_o=1 is held. A W read of TOHOST_ADDR returns 1. SB to TOHOST_ADDR raises misaligned_o and leaves tohost_data_o unchanged.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - data memory port bus between the core MEM stage and the responder
interface data_mem_responder_if #(
  parameter int size = 32
) ();
  logic            data_mem_rw;
  logic [size-1:0] data_mem_addr_i;
  logic [size-1:0] data_mem_data_wr_data;
  logic [2:0]      data_mem_control;
  logic [size-1:0] data_mem_data_rd_data;

  modport master (
    output data_mem_rw, data_mem_addr_i, data_mem_data_wr_data, data_mem_control,
    input  data_mem_data_rd_data
  );

  modport slave (
    input  data_mem_rw, data_mem_addr_i, data_mem_data_wr_data, data_mem_control,
    output data_mem_data_rd_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM with byte-lane writes, extended loads, misalignment flag and tohost register
module data_mem_responder #(
  parameter int          size        = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_responder_if.slave bus,
  output logic              misaligned_o,
  output logic              tohost_valid_o,
  output logic [size-1:0]   tohost_data_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  logic [31:0] mem [DEPTH_WORDS];

  logic          rw;
  logic [31:0]   addr;
  logic [31:0]   wr_data;
  logic [2:0]    control;
  logic [AW-1:0] word_idx;
  logic          is_tohost;
  logic          width_ok;
  logic          illegal;
  logic          do_write;
  logic          tohost_wr;
  logic [3:0]    strb;
  logic [31:0]   wr_lanes;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;

  assign rw        = bus.data_mem_rw;
  assign addr      = bus.data_mem_addr_i;
  assign wr_data   = bus.data_mem_data_wr_data;
  assign control   = bus.data_mem_control;
  assign word_idx  = addr[AW+1:2];
  assign is_tohost = (addr == TOHOST_ADDR);

  always_comb begin
    width_ok = 1'b0;
    case (control)
      CTRL_B, CTRL_BU: width_ok = 1'b1;
      CTRL_H, CTRL_HU: width_ok = ~addr[0];
      CTRL_W:          width_ok = (addr[1:0] == 2'b00);
      default:         width_ok = 1'b0;
    endcase
  end

  // tohost only accepts full-word stores; narrower stores there are rejected
  assign illegal   = ~width_ok | (rw & is_tohost & (control != CTRL_W));
  assign do_write  = rw & ~illegal & ~is_tohost & ~reset;
  assign tohost_wr = rw & ~illegal & is_tohost & ~reset;

  always_comb begin
    strb     = 4'b0000;
    wr_lanes = wr_data;
    case (control)
      CTRL_B: begin
        strb     = 4'b0001 << addr[1:0];
        wr_lanes = {4{wr_data[7:0]}};
      end
      CTRL_H: begin
        strb     = addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_data[15:0]}};
      end
      CTRL_W:  strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // reading the array combinationally lets a write from the previous edge be seen immediately
  assign rd_word = is_tohost ? tohost_data_o : mem[word_idx];
  assign rd_byte = rd_word[8*addr[1:0] +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'h0;
    case (control)
      CTRL_B:  load_val = {{24{rd_byte[7]}}, rd_byte};
      CTRL_BU: load_val = {24'h0, rd_byte};
      CTRL_H:  load_val = {{16{rd_half[15]}}, rd_half};
      CTRL_HU: load_val = {16'h0, rd_half};
      CTRL_W:  load_val = rd_word;
      default: load_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_mem_data_rd_data <= '0;
      misaligned_o              <= 1'b0;
      tohost_valid_o            <= 1'b0;
      tohost_data_o             <= '0;
    end else begin
      bus.data_mem_data_rd_data <= (rw | illegal) ? 32'h0 : load_val;
      misaligned_o              <= illegal;
      tohost_valid_o            <= tohost_wr;
      if (tohost_wr) tohost_data_o <= wr_data;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] TOHOST = 32'h0000_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        misaligned_o;
  logic        tohost_valid_o;
  logic [31:0] tohost_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder_if #(.size(32)) bus ();

  data_mem_responder #(.size(32), .DEPTH_WORDS(DEPTH), .TOHOST_ADDR(TOHOST)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .misaligned_o   (misaligned_o),
    .tohost_valid_o (tohost_valid_o),
    .tohost_data_o  (tohost_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl);
    bus.data_mem_rw           = rw;
    bus.data_mem_addr_i       = addr;
    bus.data_mem_data_wr_data = wdata;
    bus.data_mem_control      = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] ctrl, input logic [31:0] exp_rd, input logic exp_mis);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.ctrl = ctrl;
    v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  initial begin
    add(1, 32'h20, 32'h11223344, 3'b010, 32'h0, 0);
    add(1, 32'h21, 32'h00000080, 3'b000, 32'h0, 0);
    add(0, 32'h21, 32'h0,        3'b000, 32'hFFFFFF80, 0);
    add(0, 32'h21, 32'h0,        3'b100, 32'h00000080, 0);
    add(0, 32'h20, 32'h0,        3'b010, 32'h11228044, 0);
    add(1, 32'h40, 32'h01020304, 3'b010, 32'h0, 0);
    add(1, 32'h42, 32'h0000BEEF, 3'b001, 32'h0, 0);
    add(0, 32'h42, 32'h0,        3'b001, 32'hFFFFBEEF, 0);
    add(0, 32'h42, 32'h0,        3'b101, 32'h0000BEEF, 0);
    add(0, 32'h40, 32'h0,        3'b010, 32'hBEEF0304, 0);
    add(1, 32'h43, 32'hCAFEBABE, 3'b010, 32'h0, 1);
    add(0, 32'h40, 32'h0,        3'b010, 32'hBEEF0304, 0);
    add(0, 32'h41, 32'h0,        3'b001, 32'h0, 1);
    add(0, 32'h40, 32'h0,        3'b011, 32'h0, 1);
    add(1, 32'h40, 32'hFFFFFFFF, 3'b110, 32'h0, 1);
    add(0, 32'h40, 32'h0,        3'b010, 32'hBEEF0304, 0);
    add(0, 32'h43, 32'h0,        3'b000, 32'hFFFFFFBE, 0);
    add(0, 32'h40, 32'h0,        3'b101, 32'h00000304, 0);
    add(1, 32'h100, 32'h5A5A5A5A, 3'b010, 32'h0, 0);
    add(0, 32'h100, 32'h0,       3'b010, 32'h5A5A5A5A, 0);
    add(0, 32'h100 + 4*DEPTH, 32'h0, 3'b010, 32'h5A5A5A5A, 0);

    // reset with a preloaded word, then a dropped write during reset
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 3'b010);
    step();
    reset = 1'b0;
    drive(1, 32'h10, 32'h12345678, 3'b010);
    step();
    reset = 1'b1;
    drive(1, 32'h10, 32'hDEADBEEF, 3'b010);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_rd", bus.data_mem_data_rd_data, 32'h0);
      check("reset_mis", {31'h0, misaligned_o}, 32'h0);
      check("reset_tv", {31'h0, tohost_valid_o}, 32'h0);
      check("reset_td", tohost_data_o, 32'h0);
    end
    reset = 1'b0;
    drive(0, 32'h10, 32'h0, 3'b010);
    step();
    check("reset_drop", bus.data_mem_data_rd_data, 32'h12345678);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].ctrl);
      step();
      check($sformatf("vec%0d_rd", i), bus.data_mem_data_rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_mis", i), {31'h0, misaligned_o}, {31'h0, vecs[i].exp_mis});
    end

    drive(1, TOHOST, 32'h00000001, 3'b010);
    step();
    check("th_valid", {31'h0, tohost_valid_o}, 32'h1);
    check("th_data", tohost_data_o, 32'h1);
    check("th_mis", {31'h0, misaligned_o}, 32'h0);
    drive(0, TOHOST, 32'h0, 3'b010);
    step();
    check("th_valid_drop", {31'h0, tohost_valid_o}, 32'h0);
    check("th_read", bus.data_mem_data_rd_data, 32'h1);
    check("th_hold", tohost_data_o, 32'h1);
    drive(1, TOHOST, 32'h00000055, 3'b000);
    step();
    check("th_sb_mis", {31'h0, misaligned_o}, 32'h1);
    check("th_sb_valid", {31'h0, tohost_valid_o}, 32'h0);
    check("th_sb_data", tohost_data_o, 32'h1);
    drive(0, 32'h0, 32'h0, 3'b010);
    step();
    check("th_after", tohost_data_o, 32'h1);
    check("th_mis_clear", {31'h0, misaligned_o}, 32'h0);
    reset = 1'b1;
    step();
    check("th_reset", tohost_data_o, 32'h0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
